// File: rtl/serial_comparator.sv
`default_nettype none
// ============================================================================
// serial_comparator : bit-serial MSB-first magnitude comparator, early exit
// Rev 1.0
// ============================================================================
module serial_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             a_greater_b,
    output logic             a_equals_b,
    output logic             a_smaller_b
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0]       S_IDLE    = 1'b0;
    localparam logic [0:0]       S_COMPARE = 1'b1;
    localparam logic [IDX_W-1:0] C_MSB_IDX = IDX_W'(WIDTH - 1);
    localparam logic [IDX_W-1:0] C_ONE     = IDX_W'(1);

    logic [0:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             signed_q, signed_d;
    logic [IDX_W-1:0] idx_q,    idx_d;
    logic             done_q,   done_d;
    logic             gt_q,     gt_d;
    logic             eq_q,     eq_d;
    logic             lt_q,     lt_d;

    logic w_bit_a;
    logic w_bit_b;
    logic w_a_wins;

    assign w_bit_a  = a_q[idx_q];
    assign w_bit_b  = b_q[idx_q];
    // A one in the sign position means A is the negative operand, so it loses.
    assign w_a_wins = (signed_q && (idx_q == C_MSB_IDX)) ? ~w_bit_a : w_bit_a;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            eq_q     <= 1'b0;
            lt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            gt_q     <= gt_d;
            eq_q     <= eq_d;
            lt_q     <= lt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        gt_d     = gt_q;
        eq_d     = eq_q;
        lt_d     = lt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    signed_d = signed_mode;
                    idx_d    = C_MSB_IDX;
                    gt_d     = 1'b0;
                    eq_d     = 1'b0;
                    lt_d     = 1'b0;
                    state_d  = S_COMPARE;
                end
            end
            S_COMPARE: begin
                if (w_bit_a != w_bit_b) begin
                    gt_d    = w_a_wins;
                    lt_d    = ~w_a_wins;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (idx_q == '0) begin
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d   = idx_q - C_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q == S_COMPARE);
        done        = done_q;
        a_greater_b = gt_q;
        a_equals_b  = eq_q;
        a_smaller_b = lt_q;
    end

endmodule
`default_nettype wire
